// File: rtl/uart_rx_16x.sv
// UART receiver with 16x oversampling, mid-bit sampling and a one-deep
// output holding register. Unconsumed bytes are never overwritten.
// Ports:
//   clk       : clock, all state changes on its rising edge
//   reset     : synchronous active-high reset
//   tick      : one-clk enable at 16x the baud rate
//   rxd       : asynchronous serial input, idle high
//   rx_data   : last accepted data word, LSB-aligned
//   rx_valid  : rx_data holds an unconsumed word
//   rx_ready  : consumer takes rx_data when rx_valid && rx_ready
//   frame_err : one-clk pulse when a stop bit samples low
//   overrun   : sticky, a completed word was dropped
//   busy      : receiver is inside a frame (not IDLE)
module uart_rx_16x #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [3:0]           r_cnt;
  logic [2:0]           r_bits;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  logic w_accept;
  logic w_take;

  // Good stop bit sampled at its midpoint completes a frame.
  assign w_accept = tick && (r_state == STOP) &&
                    (r_cnt == 4'd15) && r_sync2;
  assign w_take   = r_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Start bit is checked at count 7 (its middle); data and stop bits
  // are then sampled every 16 ticks, i.e. at their middles too.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_bits  <= 3'd0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (tick) begin
        unique case (r_state)
          IDLE: begin
            if (!r_sync2) begin
              r_state <= START;
              r_cnt   <= 4'd0;
            end
          end
          START: begin
            if (r_cnt == 4'd7) begin
              if (!r_sync2) begin
                r_state <= DATA;
                r_cnt   <= 4'd0;
                r_bits  <= 3'd0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          DATA: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              // LSB arrives first, so shift right from the top.
              r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
              if (r_bits == LAST_BIT) begin
                r_state <= STOP;
                r_cnt   <= 4'd0;
              end else begin
                r_bits <= r_bits + 3'd1;
              end
            end
          end
          STOP: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= IDLE;
              if (!r_sync2) begin
                r_ferr <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Holding register: a new word may replace the old one only in the
  // same clk that the old one is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_accept && (!r_valid || rx_ready)) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else begin
      if (w_accept) begin
        r_ovr <= 1'b1;
      end
      if (w_take) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != IDLE);

endmodule
